// File: rtl/taxi_eth_lb_pkg.sv
// Shared types and helpers for the loopback MAC-swap path.
package taxi_eth_lb_pkg;

  typedef enum logic [1:0] {IDLE, WAIT1, BODY} lb_state_t;

  localparam int unsigned ETH_DST_OFS       = 0;
  localparam int unsigned ETH_SRC_OFS       = 6;
  localparam int unsigned ETH_HDR_MAC_BYTES = 12;

  typedef struct packed {
    logic [63:0] beat1;
    logic [63:0] beat0;
  } mac_pair_t;

  // Exchanges frame bytes 0-5 with 6-11 across the first two 64-bit beats.
  function automatic mac_pair_t mac_swap_beats(input logic [63:0] beat0, input logic [63:0] beat1);
    logic [127:0] in_b;
    logic [127:0] out_b;
    in_b  = {beat1, beat0};
    out_b = in_b;
    for (int unsigned i = 0; i < ETH_HDR_MAC_BYTES / 2; i++) begin
      out_b[8*(ETH_DST_OFS+i) +: 8] = in_b[8*(ETH_SRC_OFS+i) +: 8];
      out_b[8*(ETH_SRC_OFS+i) +: 8] = in_b[8*(ETH_DST_OFS+i) +: 8];
    end
    return out_b;
  endfunction

endpackage

// File: rtl/taxi_axis_if.sv
// AXI4-Stream bundle used between the async FIFO, the MAC-swap block and the MAC.
interface taxi_axis_if #(
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W / 8,
  parameter int ID_W   = 8,
  parameter int USER_W = 1
);
  logic [DATA_W-1:0] tdata;
  logic [KEEP_W-1:0] tkeep;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [ID_W-1:0]   tid;
  logic [USER_W-1:0] tuser;

  modport src (output tdata, tkeep, tvalid, tlast, tid, tuser, input tready);
  modport snk (input tdata, tkeep, tvalid, tlast, tid, tuser, output tready);
endinterface

// File: rtl/taxi_eth_lb_skid.sv
// One-beat register slice; accepts a new beat whenever empty or draining.
module taxi_eth_lb_skid #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);
  logic         valid_q;
  logic [W-1:0] data_q;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;
  assign out_data  = data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (in_ready) begin
      valid_q <= in_valid;
      if (in_valid) begin
        data_q <= in_data;
      end
    end
  end
endmodule

// File: rtl/taxi_eth_lb_mac_swap.sv
// Loopback header rewriter: swaps Ethernet dst/src MACs through a hold (H) and output (O) slice.
// Statistics counters are built only when TAXI_ETH_LB_MAC_SWAP_STATS_EN is defined.
module taxi_eth_lb_mac_swap
  import taxi_eth_lb_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int KEEP_W = DATA_W / 8,
  parameter int ID_W   = 8,
  parameter int USER_W = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  taxi_axis_if.snk    s_axis,
  taxi_axis_if.src    m_axis,
  input  logic        cfg_swap_en,
  output logic [31:0] stat_frame_cnt,
  output logic [31:0] stat_runt_cnt
);

  if (DATA_W != 64 || KEEP_W != 8) begin : g_bad_width
    $error("taxi_eth_lb_mac_swap supports only DATA_W=64, KEEP_W=8");
  end

  typedef struct packed {
    logic              runt;
    logic [USER_W-1:0] tuser;
    logic [ID_W-1:0]   tid;
    logic              tlast;
    logic [KEEP_W-1:0] tkeep;
    logic [DATA_W-1:0] tdata;
  } beat_t;

  localparam int BEAT_W = $bits(beat_t);

  lb_state_t state_q, state_d;
  logic      swap_q, swap_d;
  beat_t     s_beat, h_in, h_beat, o_in, o_beat;
  logic      h_in_ready, h_valid, h_out_ready;
  logic      o_in_valid, o_in_ready, o_valid;
  logic      s_fire, m_fire, h_move_ok, runt_last;
  mac_pair_t swapped;

  assign s_beat = {1'b0, s_axis.tuser, s_axis.tid, s_axis.tlast, s_axis.tkeep, s_axis.tdata};

  // In WAIT1 beat 0 may only leave H together with beat 1 arriving, so tready follows tvalid there.
  assign s_axis.tready = rst_n && h_in_ready;
  assign s_fire        = s_axis.tvalid && s_axis.tready;
  assign h_move_ok     = (state_q != WAIT1) || s_axis.tvalid;
  assign h_out_ready   = o_in_ready && h_move_ok;
  assign o_in_valid    = h_valid && h_move_ok;
  assign runt_last     = s_axis.tlast && (s_axis.tkeep[3:0] != 4'hF);
  assign swapped       = mac_swap_beats(h_beat.tdata, s_axis.tdata);

  always_comb begin
    state_d = state_q;
    swap_d  = swap_q;
    h_in    = s_beat;
    o_in    = h_beat;
    case (state_q)
      IDLE: begin
        if (s_fire) begin
          if (s_axis.tlast) begin
            h_in.runt = 1'b1;
          end else begin
            state_d = WAIT1;
            swap_d  = cfg_swap_en;
          end
        end
      end
      WAIT1: begin
        if (s_fire) begin
          h_in.runt = runt_last;
          if (swap_q && !runt_last) begin
            o_in.tdata = swapped.beat0;
            h_in.tdata = swapped.beat1;
          end
          state_d = s_axis.tlast ? IDLE : BODY;
        end
      end
      BODY: begin
        if (s_fire && s_axis.tlast) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      swap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      swap_q  <= swap_d;
    end
  end

  taxi_eth_lb_skid #(.W(BEAT_W)) u_hold (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (s_fire),
    .in_ready  (h_in_ready),
    .in_data   (h_in),
    .out_valid (h_valid),
    .out_ready (h_out_ready),
    .out_data  (h_beat)
  );

  taxi_eth_lb_skid #(.W(BEAT_W)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (o_in_valid),
    .in_ready  (o_in_ready),
    .in_data   (o_in),
    .out_valid (o_valid),
    .out_ready (m_axis.tready),
    .out_data  (o_beat)
  );

  assign m_axis.tvalid = o_valid;
  assign m_axis.tdata  = o_beat.tdata;
  assign m_axis.tkeep  = o_beat.tkeep;
  assign m_axis.tlast  = o_beat.tlast;
  assign m_axis.tid    = o_beat.tid;
  assign m_axis.tuser  = o_beat.tuser;
  assign m_fire        = o_valid && m_axis.tready;

`ifdef TAXI_ETH_LB_MAC_SWAP_STATS_EN
  logic [31:0] frame_cnt_q, runt_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      runt_cnt_q  <= '0;
    end else if (m_fire && o_beat.tlast) begin
      frame_cnt_q <= frame_cnt_q + 32'd1;
      if (o_beat.runt) begin
        runt_cnt_q <= runt_cnt_q + 32'd1;
      end
    end
  end

  assign stat_frame_cnt = frame_cnt_q;
  assign stat_runt_cnt  = runt_cnt_q;
`else
  logic unused_stats;
  assign unused_stats   = ^{m_fire, o_beat.runt};
  assign stat_frame_cnt = '0;
  assign stat_runt_cnt  = '0;
`endif

endmodule

// File: doc/taxi_eth_lb_mac_swap.md
Name: taxi_eth_lb_mac_swap

Overview:
- Frame loopback header rewriter on the 64-bit QSFP channel path: sits between the per-channel RX→TX async FIFO output and the 25G MAC transmit stream.
- Swaps Ethernet destination and source MAC addresses in each frame so looped-back frames return to the sender.
- Passes all other bytes, tid and tuser unchanged.
- Runs in the MAC TX clock domain.

Parameters:
- DATA_W, 64, tdata width; only 64 is supported; elaboration error otherwise.
- KEEP_W, DATA_W/8, tkeep width; must equal 8.
- ID_W, 8, tid width, passed through.
- USER_W, 1, tuser width, passed through; bit 0 is the bad-frame flag.

Ports:
- clk  in  1  stream clock (MAC TX clock).
- rst_n  in  1  reset: asynchronous assert, active-low.
- s_axis  taxi_axis_if.snk  DATA_W  input frames from the async FIFO.
- m_axis  taxi_axis_if.src  DATA_W  rewritten frames to the MAC TX.
- cfg_swap_en  in  1  swap enable; sampled when beat 0 of a frame is accepted.
- stat_frame_cnt  out  32  frames forwarded (macro-gated).
- stat_runt_cnt  out  32  frames forwarded unmodified because they were too short (macro-gated).

Behaviour:
- Byte mapping: byte k is at tdata[8k+7:8k]. Frame bytes 0-5 are dst, bytes 6-11 are src.
  - Beat 0 = dst[0:5], src[0:1].
  - Beat 1 = src[2:5], bytes 12-15.
- Output beats:
  - Beat 0' = src[0:5], dst[0:1].
  - Beat 1' = dst[2:5], bytes 12-15 unchanged.
  - tkeep, tlast, tid, tuser are copied per beat.
- Datapath: hold register H (one beat plus valid) feeding output register O. m_axis is driven only from O, with no combinational path from s_axis to m_axis.
- FSM states and transitions:
  - IDLE: no frame in progress.
    - Accepting beat 0 with tlast=1 → beat forwarded unmodified, runt counted, stay IDLE.
    - Otherwise beat 0 goes to H, swap flag latched from cfg_swap_en, go WAIT1.
  - WAIT1: beat 0 held.
    - On acceptance of beat 1, a frame is a runt when beat 1 has tlast=1 and tkeep[3:0]!=4'hF.
    - Runt or swap flag=0: both beats forwarded unmodified.
    - Otherwise rewritten.
    - Then go BODY, or IDLE if beat 1 had tlast.
  - BODY: beats pass through H→O unchanged. Accepting tlast → IDLE.
- Handshake:
  - O loads whenever O is empty or m_axis.tready=1.
  - s_axis.tready=1 when H is empty, or when H can move to O in the same cycle.
  - Sustained throughput is 1 beat/cycle with m_axis.tready held high.
  - No bubble between frames: a new beat 0 may enter H in the cycle the previous tlast moves H→O.
- Latency: beat 0' appears on m_axis the cycle after beat 1 is accepted. Later beats appear 2 cycles after acceptance at full rate.
- Backpressure: m_axis.tready=0 freezes O and H; tvalid stays asserted and data is stable (AXIS rule).
- tuser[0]=1 on tlast is forwarded unchanged; the frame is still swapped and still counted.
- Reset (async, mid-frame included):
  - H and O are invalidated, FSM goes to IDLE.
  - m_axis.tvalid=0, tdata/tkeep/tid/tuser=0, tlast=0.
  - Counters=0; s_axis.tready=0 during reset.
  - Any partial frame is discarded; the next accepted beat is treated as beat 0.
- Counters: 32-bit, wrapping at 2^32. Incremented when a frame's tlast beat leaves O (handshake on m_axis). The runt count is a subset of the frame count.

Optional Feature:
- Macro: TAXI_ETH_LB_MAC_SWAP_STATS_EN.
- Defined: stat_frame_cnt and stat_runt_cnt registers are implemented as above.
- Undefined: counter logic is omitted; both outputs are tied to 32'd0; ports remain for a stable interface.

Decomposition:
- Shared package taxi_eth_lb_pkg holds:
  - enum lb_state_t {IDLE, WAIT1, BODY}.
  - localparams ETH_DST_OFS=0, ETH_SRC_OFS=6, ETH_HDR_MAC_BYTES=12.
  - function mac_swap_beats(beat0, beat1) returning the rewritten pair.
- One sub-module: taxi_eth_lb_skid, a one-beat register slice used for H/O with full-throughput ready logic.

Test Plan:
- 64-byte frame, dst 02:00:00:00:00:01, src 02:00:00:00:00:02, cfg_swap_en=1, tready=1 → output dst 02:..:02, src 02:..:01; bytes 12-63 identical; beat 0' one cycle after beat 1 accepted; frame_cnt=1.
- Same frame with cfg_swap_en=0, toggled to 1 mid-frame → output identical to input (flag latched at beat 0).
- Runt frames → both forwarded unmodified, runt_cnt=2, frame_cnt=2:
  - a 6-byte frame (tlast on beat 0, tkeep=8'h3F);
  - a 10-byte frame (beat 1 tkeep=8'h03).
- 100 back-to-back 64-byte frames with random m_axis.tready (50%) → every frame swapped, payloads intact, tdata stable while stalled, frame_cnt=100; with tready=1, zero idle cycles between frames.
- Assert rst_n low during beat 3 of a frame, then release and send a fresh frame → m_axis.tvalid=0 immediately on assert; the fresh frame is swapped correctly; counters restart at 0.
- Frame with tuser=1 and tid=8'h5A on tlast → output last beat tuser=1, all beats tid=8'h5A, swap applied.
